// File: rtl/itch_framer.sv
// Store-and-forward framer: splits a length-prefixed byte stream into ITCH messages and
// replays each stored payload as a gap-free burst with start/end markers.
module itch_framer #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  message,
  output logic        valid,
  output logic        start_msg,
  output logic        end_msg,
  output logic        framing_err,
  output logic [31:0] msg_count,
  output logic [15:0] drop_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {StLenHi, StLenLo, StPayload, StDiscard} in_state_e;
  typedef enum logic {StIdle, StSend} out_state_e;

  in_state_e   in_st_q;
  out_state_e  out_st_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [15:0] out_rem_q;
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]  lwr_q, lrd_q;
  logic        rdy_en_q;
  logic [7:0]  mem [DEPTH];
  logic [15:0] lfifo [4];

  logic        accept;
  logic [PW:0] used;
  logic [2:0]  lused;
  logic        lempty;
  logic        lfull;
  logic [15:0] new_len;
  logic        mem_we;
  logic        len_we;
  logic [15:0] pop_len;

  always_comb begin
    accept  = in_valid && in_ready;
    used    = wr_ptr_q - rd_ptr_q;
    lused   = lwr_q - lrd_q;
    lempty  = (lused == 3'd0);
    lfull   = (lused == 3'd4);
    new_len = {len_q[15:8], in_data};
    mem_we  = accept && (in_st_q == StPayload);
    len_we  = mem_we && (cnt_q == 16'd1);
    pop_len = lfifo[lrd_q[1:0]];
    // Only gate at a frame boundary: a started frame always has room reserved for it.
    in_ready = rdy_en_q &&
               !((in_st_q == StLenHi) && ((32'(used) > (DEPTH - MAX_LEN)) || lfull));
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[PW-1:0]] <= in_data;
    if (len_we) lfifo[lwr_q[1:0]] <= len_q;
  end

  // Input side: parse the length prefix, store or discard the payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_st_q     <= StLenHi;
      len_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      lwr_q       <= '0;
      rdy_en_q    <= 1'b0;
      framing_err <= 1'b0;
      drop_count  <= '0;
    end else begin
      rdy_en_q    <= 1'b1;
      framing_err <= 1'b0;
      if (accept) begin
        unique case (in_st_q)
          StLenHi: begin
            len_q[15:8] <= in_data;
            in_st_q     <= StLenLo;
          end
          StLenLo: begin
            len_q[7:0] <= in_data;
            cnt_q      <= new_len;
            if (new_len == 16'd0) begin
              in_st_q <= StLenHi;
            end else if (32'(new_len) > MAX_LEN) begin
              in_st_q     <= StDiscard;
              framing_err <= 1'b1;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else begin
              in_st_q <= StPayload;
            end
          end
          StPayload: begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            cnt_q    <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              lwr_q   <= lwr_q + 3'd1;
              in_st_q <= StLenHi;
            end
          end
          StDiscard: begin
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) in_st_q <= StLenHi;
          end
        endcase
      end
    end
  end

  // Output side: out_rem_q counts bytes still owed by the frame being sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_st_q  <= StIdle;
      out_rem_q <= '0;
      rd_ptr_q  <= '0;
      lrd_q     <= '0;
      message   <= '0;
      valid     <= 1'b0;
      start_msg <= 1'b0;
      end_msg   <= 1'b0;
      msg_count <= '0;
    end else if (out_rem_q != 16'd0) begin
      message   <= mem[rd_ptr_q[PW-1:0]];
      rd_ptr_q  <= rd_ptr_q + 1'b1;
      valid     <= 1'b1;
      start_msg <= 1'b0;
      end_msg   <= (out_rem_q == 16'd1);
      out_rem_q <= out_rem_q - 16'd1;
      if (out_rem_q == 16'd1) msg_count <= msg_count + 32'd1;
    end else if (!lempty) begin
      // Pop and emit the first byte together so consecutive frames abut.
      out_st_q  <= StSend;
      lrd_q     <= lrd_q + 3'd1;
      message   <= mem[rd_ptr_q[PW-1:0]];
      rd_ptr_q  <= rd_ptr_q + 1'b1;
      valid     <= 1'b1;
      start_msg <= 1'b1;
      end_msg   <= (pop_len == 16'd1);
      out_rem_q <= pop_len - 16'd1;
      if (pop_len == 16'd1) msg_count <= msg_count + 32'd1;
    end else begin
      out_st_q  <= StIdle;
      message   <= '0;
      valid     <= 1'b0;
      start_msg <= 1'b0;
      end_msg   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_itch_framer.sv
// Randomized bench for itch_framer: a queue-based model of expected frames is checked
// against the emitted byte stream, counters and timing.
module tb_itch_framer;

  localparam int MAX_LEN = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  message;
  logic        valid, start_msg, end_msg, framing_err;
  logic [31:0] msg_count;
  logic [15:0] drop_count;

  itch_framer #(.DEPTH(128), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .message    (message),
    .valid      (valid),
    .start_msg  (start_msg),
    .end_msg    (end_msg),
    .framing_err(framing_err),
    .msg_count  (msg_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];
  int         exp_lens[$];
  int         exp_msgs = 0;
  int         exp_drops = 0;
  int         exp_ferr = 0;
  int         ferr_seen = 0;
  int         stored = 0;
  int         started = 0;
  int         last_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: content/order against the model, gap-free bursts, idle-zero outputs.
  bit in_frame = 0;
  bit b2b_pend = 0;
  int cur_len = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      b2b_pend = 0;
      cur_len  = 0;
    end else begin
      if (b2b_pend) chk("b2b_start", {31'd0, start_msg}, 32'd1);
      b2b_pend = 0;
      if (framing_err) ferr_seen++;
      if (!valid) begin
        chk("idle_zero", {22'd0, message, start_msg, end_msg}, 32'd0);
        if (in_frame) chk("gap_free", {31'd0, valid}, 32'd1);
      end else begin
        if (start_msg) begin
          chk("start_in_frame", {31'd0, in_frame}, 32'd0);
          in_frame = 1;
          cur_len  = 0;
          started++;
        end
        if (exp_bytes.size() == 0) chk("spurious_byte", {31'd0, valid}, 32'd0);
        else chk("byte", {24'd0, message}, {24'd0, exp_bytes.pop_front()});
        cur_len++;
        if (end_msg) begin
          if (exp_lens.size() == 0) chk("spurious_end", {31'd0, end_msg}, 32'd0);
          else chk("frame_len", cur_len, exp_lens.pop_front());
          in_frame = 0;
          b2b_pend = (stored > started);
        end
      end
    end
  end

  // mode: 0 no gaps, 1 idle before every payload byte, 2 random idles
  task automatic send_byte(input logic [7:0] b, input int mode);
    int n;
    if (mode == 1 || (mode == 2 && $urandom_range(3) == 0)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    last_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] first, input int mode);
    logic [7:0] pl[$];
    logic [15:0] l16;
    l16 = 16'(len);
    for (int i = 0; i < len; i++) pl.push_back(i == 0 ? first : 8'($urandom));
    send_byte(l16[15:8], 0);
    send_byte(l16[7:0], 0);
    for (int i = 0; i < len; i++) send_byte(pl[i], i == 0 ? 0 : mode);
    if (len > MAX_LEN) begin
      exp_drops++;
      exp_ferr++;
    end else if (len > 0) begin
      foreach (pl[i]) exp_bytes.push_back(pl[i]);
      exp_lens.push_back(len);
      exp_msgs++;
      stored++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_lens.size() != 0 || valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_lens.size(), 32'd0);
  endtask

  task automatic clear_model();
    exp_bytes.delete();
    exp_lens.delete();
    exp_msgs  = 0;
    exp_drops = 0;
    stored    = 0;
    started   = 0;
  endtask

  initial begin
    // Reset state and in_ready release
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outs", {22'd0, message, valid, start_msg}, 32'd0);
    chk("rst_end_ferr", {30'd0, end_msg, framing_err}, 32'd0);
    chk("rst_msg_count", msg_count, 32'd0);
    chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_edge", {31'd0, in_ready}, 32'd1);

    // 19-byte 'D' message with N+2 latency
    send_frame(19, 8'h44, 0);
    @(negedge clk);
    chk("latency_cycle", cyc, last_cyc + 2);
    chk("latency_start", {31'd0, start_msg}, 32'd1);
    chk("latency_byte", {24'd0, message}, 32'h44);
    drain();
    chk("count_d", msg_count, exp_msgs);

    // Back-to-back A/F frames
    send_frame(36, 8'h41, 0);
    send_frame(40, 8'h46, 0);
    drain();
    chk("count_af", msg_count, exp_msgs);

    // Oversize frame, then a one-byte frame
    send_frame(80, 8'h55, 0);
    send_frame(1, 8'h41, 0);
    @(negedge clk);
    chk("one_byte_flags", {29'd0, valid, start_msg, end_msg}, 32'd7);
    chk("one_byte_data", {24'd0, message}, 32'h41);
    drain();
    chk("drop_one", {16'd0, drop_count}, exp_drops);

    // Length boundaries: 0, MAX_LEN, MAX_LEN+1
    send_frame(0, 8'h00, 0);
    send_frame(MAX_LEN, 8'h50, 0);
    send_frame(MAX_LEN + 1, 8'h51, 0);
    drain();
    chk("bound_msgs", msg_count, exp_msgs);
    chk("bound_drops", {16'd0, drop_count}, exp_drops);

    // Alternating in_valid gaps mid-payload
    for (int i = 0; i < 3; i++) send_frame(5 + 7 * i, 8'h45, 1);
    drain();

    // Streams of 0x28-byte frames
    for (int i = 0; i < 8; i++) send_frame(40, 8'(8'h60 + i), 0);
    drain();
    chk("fill_msgs", msg_count, exp_msgs);

    // Randomized frames including oversize, empty and short frames
    for (int i = 0; i < 30; i++) begin
      int r, len;
      r = int'($urandom_range(9));
      if (r == 0) len = 0;
      else if (r == 1) len = MAX_LEN + 1 + int'($urandom_range(20));
      else if (r == 2) len = MAX_LEN;
      else if (r == 3) len = 1;
      else len = 2 + int'($urandom_range(MAX_LEN - 3));
      send_frame(len, 8'($urandom), 2);
    end
    drain();
    chk("rand_msgs", msg_count, exp_msgs);
    chk("rand_drops", {16'd0, drop_count}, exp_drops);
    chk("ferr_pulses", ferr_seen, exp_ferr);

    // Reset mid-frame after 10 of 19 payload bytes
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    for (int i = 0; i < 10; i++) send_byte(8'(i), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {21'd0, message, valid, start_msg, end_msg}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_counts", msg_count | {16'd0, drop_count}, 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(19, 8'h44, 0);
    drain();
    repeat (5) @(negedge clk);
    chk("post_rst_count", msg_count, 32'd1);
    chk("post_rst_drops", {16'd0, drop_count}, 32'd0);
    chk("bytes_left", exp_bytes.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/itch_framer.md
ITCH_FRAMER -- requirements
Module: itch_framer

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning payload byte-FIFO depth (power of 2, >= 2*MAX_LEN).
REQ-002 SHALL have parameter MAX_LEN, default 64, meaning the largest payload length accepted; longer frames are discarded.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  8  upstream byte stream: 2-byte big-endian length prefix, then payload bytes.
REQ-006 in_valid  input  1  in_data valid; a byte is accepted when in_valid && in_ready.
REQ-007 in_ready  output  1  framer can accept a byte.
REQ-008 message  output  8  payload byte to the ITCH parser.
REQ-009 valid  output  1  message byte valid; high only on payload bytes.
REQ-010 start_msg  output  1  first payload byte (message type) of a frame.
REQ-011 end_msg  output  1  last payload byte of a frame.
REQ-012 framing_err  output  1  one-cycle pulse when an oversize frame is detected.
REQ-013 msg_count  output  32  number of frames emitted; wraps at 2^32.
REQ-014 drop_count  output  16  number of frames discarded; saturates at 0xFFFF.

Function
REQ-015 Input FSM SHALL have states LEN_HI, LEN_LO, PAYLOAD, DISCARD; it advances only on accepted bytes.
REQ-016 LEN_HI: accepted byte -> L[15:8], go LEN_LO.
REQ-017 LEN_LO: accepted byte -> L[7:0]; L==0 -> LEN_HI, no output and no count change; L>MAX_LEN -> DISCARD, framing_err pulse, drop_count+1; otherwise -> PAYLOAD.
REQ-018 PAYLOAD: each accepted byte is written to the FIFO; on the L-th byte, push L to a 4-entry length FIFO and return to LEN_HI.
REQ-019 DISCARD: accept and drop L bytes, with in_ready held high, then return to LEN_HI.
REQ-020 in_ready SHALL be low only in LEN_HI when (FIFO free space < MAX_LEN) or the length FIFO is full; it is high in all other states, so no accepted frame can overflow.
REQ-021 Output FSM SHALL have states IDLE and SEND; IDLE with the length FIFO non-empty -> pop length, go SEND.
REQ-022 SEND SHALL emit one byte per cycle with no gaps, valid=1; start_msg on byte 1 and end_msg on byte L. For L==1, start_msg and end_msg are asserted together.
REQ-023 After end_msg, if another length is queued, its start_msg SHALL appear on the very next cycle; otherwise go IDLE.
REQ-024 A frame SHALL NOT begin output before all of its payload bytes are stored (store-and-forward), because the downstream parser flags any mid-message gap as invalid.
REQ-025 Latency: last payload byte accepted in cycle N with output IDLE -> start_msg registered high in cycle N+2.
REQ-026 Outputs SHALL be registered; message SHALL be 0 whenever valid=0; start_msg and end_msg SHALL never be high without valid.
REQ-027 A simultaneous FIFO write and read in the same cycle SHALL both complete; pointers wrap modulo DEPTH.
REQ-028 msg_count SHALL increment in the cycle end_msg is driven.

Reset
REQ-029 rst high SHALL force, immediately: in_ready=0, valid=0, start_msg=0, end_msg=0, framing_err=0, message=0, msg_count=0, drop_count=0; input FSM to LEN_HI, output FSM to IDLE; FIFO pointers and the length FIFO empty.
REQ-030 After rst deasserts, in_ready SHALL rise on the next clock edge.
REQ-031 Reset mid-frame SHALL discard all partial and queued frames; no partial frame may be emitted after reset.

Verification
REQ-032 Stream 00 13 + 19-byte D message (44 ...) back-to-back -> 19 contiguous valid cycles, start_msg on 0x44, end_msg on byte 19, start at N+2, msg_count=1.
REQ-033 Frames of L=0x24 (A) and L=0x28 (F) sent back-to-back -> two frames with end_msg of frame 1 immediately followed by start_msg of frame 2; msg_count=2.
REQ-034 Frame L=0x0050 with MAX_LEN=64 -> framing_err pulse, 80 bytes dropped, no valid, drop_count=1; following frame 00 01 41 -> one cycle with start_msg=end_msg=valid=1, message=0x41.
REQ-035 Input with in_valid gaps mid-payload (toggling every other cycle) -> output still gap-free per frame.
REQ-036 Fill with 0x28-byte frames while output is stalled behind queue -> in_ready drops in LEN_HI at threshold, no byte lost, all frames emitted in order.
REQ-037 rst asserted after 10 of 19 payload bytes -> all outputs 0 immediately; next complete frame is emitted correctly with msg_count=1.
